// File: rtl/vid_decim_pkg.sv
// Shared types and config helpers for the video decimator.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package vid_decim_pkg;

    localparam int DEPTH = 2;
    localparam int CFG_W = 8;

    // Per-entry flags; data and user travel alongside in the buffer arrays.
    typedef struct packed {
        logic last;
        logic is_final;
    } obuf_tag_t;

    function automatic logic [CFG_W-1:0] norm_factor(input logic [CFG_W-1:0] f);
        return (f == '0) ? CFG_W'(1) : f;
    endfunction

    function automatic logic [CFG_W-1:0] norm_phase(input logic [CFG_W-1:0] p,
                                                    input logic [CFG_W-1:0] f);
        logic [CFG_W-1:0] fn;
        fn = norm_factor(f);
        return (p >= fn) ? '0 : p;
    endfunction

endpackage

// File: rtl/vid_decim_obuf.sv
// Two-entry output buffer whose tail stays open until its tlast is known.
// Latency: an entry finalized in cycle N is presented in cycle N+1.
// Backpressure: in_rdy is registered and low while both entries are occupied.
module vid_decim_obuf
    import vid_decim_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int TUSER_WIDTH = 1
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   push_vld,
    input  logic [DATA_WIDTH-1:0]  push_dat,
    input  logic [TUSER_WIDTH-1:0] push_user,
    input  logic                   push_last,
    input  logic                   push_final,
    input  logic                   fin_vld,
    input  logic                   fin_last,
    output logic                   in_rdy,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [DATA_WIDTH-1:0]  out_dat,
    output logic [TUSER_WIDTH-1:0] out_user,
    output logic                   out_last
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0]  dat_q, dat_n;
    logic [DEPTH-1:0][TUSER_WIDTH-1:0] user_q, user_n;
    obuf_tag_t [DEPTH-1:0]             tag_q, tag_n;
    logic [1:0]                        cnt_q, cnt_n;
    logic                              in_rdy_q;
    logic                              tail_idx;
    logic                              push_idx;
    logic                              pop;

    assign out_vld  = (cnt_q != 2'd0) && tag_q[0].is_final;
    assign pop      = out_vld && out_rdy;
    assign tail_idx = cnt_q[1];
    assign in_rdy   = in_rdy_q;
    assign out_dat  = dat_q[0];
    assign out_user = user_q[0];
    assign out_last = tag_q[0].last;

    // Finalize acts on the tail as it stood before this cycle's push.
    always_comb begin
        dat_n    = dat_q;
        user_n   = user_q;
        tag_n    = tag_q;
        cnt_n    = cnt_q;
        push_idx = 1'b0;
        if (fin_vld && (cnt_q != 2'd0) && !tag_q[tail_idx].is_final) begin
            tag_n[tail_idx].is_final = 1'b1;
            tag_n[tail_idx].last     = fin_last;
        end
        if (pop) begin
            dat_n[0]  = dat_n[1];
            user_n[0] = user_n[1];
            tag_n[0]  = tag_n[1];
            dat_n[1]  = '0;
            user_n[1] = '0;
            tag_n[1]  = '0;
            cnt_n     = cnt_n - 2'd1;
        end
        if (push_vld && (cnt_n != 2'd2)) begin
            push_idx                 = cnt_n[0];
            dat_n[push_idx]          = push_dat;
            user_n[push_idx]         = push_user;
            tag_n[push_idx].last     = push_last;
            tag_n[push_idx].is_final = push_final;
            cnt_n                    = cnt_n + 2'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            dat_q    <= '0;
            user_q   <= '0;
            tag_q    <= '0;
            cnt_q    <= 2'd0;
            in_rdy_q <= 1'b1;
        end else begin
            dat_q    <= dat_n;
            user_q   <= user_n;
            tag_q    <= tag_n;
            cnt_q    <= cnt_n;
            in_rdy_q <= (cnt_n != 2'd2);
        end
    end

endmodule

// File: rtl/vid_decimator.sv
// AXI4-Stream video decimator: keeps one column per h_factor and one line per v_factor.
// Latency: kept pixel appears one cycle after it is finalized (next kept beat or end of line).
// Backpressure: s_axis_tready drops while the 2-entry output buffer is full; no beat is lost.
module vid_decimator
    import vid_decim_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int TUSER_WIDTH = 1,
    parameter int MAX_FACTOR  = 8,
    parameter int FACTOR_W    = $clog2(MAX_FACTOR + 1)
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [FACTOR_W-1:0]    cfg_h_factor,
    input  logic [FACTOR_W-1:0]    cfg_v_factor,
    input  logic [FACTOR_W-1:0]    cfg_h_phase,
    input  logic [FACTOR_W-1:0]    cfg_v_phase,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   early_sof
);

    logic [FACTOR_W-1:0] h_ph_q, v_ph_q;
    logic [FACTOR_W-1:0] hf_q, vf_q, hp_q, vp_q;
    logic                mid_line_q;
    logic                sof_pend_q;
    logic                early_sof_q;

    logic [FACTOR_W-1:0] new_hf, new_vf, new_hp, new_vp;
    logic [FACTOR_W-1:0] eff_hf, eff_vf, eff_hp, eff_vp;
    logic [FACTOR_W-1:0] h_cur, v_cur, h_nxt, v_nxt;
    logic                acc, sof, keep, early;
    logic                push_vld, fin_vld, fin_last;
    logic [TUSER_WIDTH-1:0] push_user;

    assign new_hf = FACTOR_W'(norm_factor(CFG_W'(cfg_h_factor)));
    assign new_vf = FACTOR_W'(norm_factor(CFG_W'(cfg_v_factor)));
    assign new_hp = FACTOR_W'(norm_phase(CFG_W'(cfg_h_phase), CFG_W'(cfg_h_factor)));
    assign new_vp = FACTOR_W'(norm_phase(CFG_W'(cfg_v_phase), CFG_W'(cfg_v_factor)));

    // An SOF beat uses the freshly sampled config and restarts both counters.
    always_comb begin
        acc    = s_axis_tvalid && s_axis_tready;
        sof    = s_axis_tuser[0];
        eff_hf = sof ? new_hf : hf_q;
        eff_vf = sof ? new_vf : vf_q;
        eff_hp = sof ? new_hp : hp_q;
        eff_vp = sof ? new_vp : vp_q;
        h_cur  = sof ? '0 : h_ph_q;
        v_cur  = sof ? '0 : v_ph_q;
        keep   = (h_cur == eff_hp) && (v_cur == eff_vp);
        // mid_line rather than h_ph: with h_factor 1 the phase is always 0.
        early  = acc && sof && mid_line_q;

        push_vld  = acc && keep;
        fin_vld   = acc && (early || keep || s_axis_tlast);
        fin_last  = early || (!keep && s_axis_tlast);
        push_user    = s_axis_tuser;
        push_user[0] = sof_pend_q || sof;

        if (s_axis_tlast) begin
            h_nxt = '0;
            v_nxt = (v_cur == eff_vf - FACTOR_W'(1)) ? '0 : v_cur + FACTOR_W'(1);
        end else begin
            h_nxt = (h_cur == eff_hf - FACTOR_W'(1)) ? '0 : h_cur + FACTOR_W'(1);
            v_nxt = v_cur;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            h_ph_q      <= '0;
            v_ph_q      <= '0;
            hf_q        <= FACTOR_W'(1);
            vf_q        <= FACTOR_W'(1);
            hp_q        <= '0;
            vp_q        <= '0;
            mid_line_q  <= 1'b0;
            sof_pend_q  <= 1'b0;
            early_sof_q <= 1'b0;
        end else begin
            early_sof_q <= early;
            if (acc) begin
                h_ph_q     <= h_nxt;
                v_ph_q     <= v_nxt;
                mid_line_q <= !s_axis_tlast;
                sof_pend_q <= keep ? 1'b0 : (sof_pend_q || sof);
                if (sof) begin
                    hf_q <= new_hf;
                    vf_q <= new_vf;
                    hp_q <= new_hp;
                    vp_q <= new_vp;
                end
            end
        end
    end

    assign early_sof = early_sof_q;

    vid_decim_obuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .TUSER_WIDTH(TUSER_WIDTH)
    ) u_obuf (
        .aclk      (aclk),
        .areset    (areset),
        .push_vld  (push_vld),
        .push_dat  (s_axis_tdata),
        .push_user (push_user),
        .push_last (s_axis_tlast),
        .push_final(s_axis_tlast),
        .fin_vld   (fin_vld),
        .fin_last  (fin_last),
        .in_rdy    (s_axis_tready),
        .out_vld   (m_axis_tvalid),
        .out_rdy   (m_axis_tready),
        .out_dat   (m_axis_tdata),
        .out_user  (m_axis_tuser),
        .out_last  (m_axis_tlast)
    );

endmodule
